alu_exec_unit: RTL and testbench



---
 rtl/alu_defs_pkg.sv | 18 +
 rtl/mul_shift_add.sv | 60 ++++++
 rtl/alu_exec_unit.sv | 121 ++++++++++++
 tb/tb_alu_exec_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Shared ALU op codes, exec-unit FSM encodings and default datapath width.
package alu_defs;
  localparam int DEF_WIDTH = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;
endpackage

// File: rtl/mul_shift_add.sv
// Unsigned shift-add multiplier core: one partial product per step, WIDTH steps.
module mul_shift_add
  import alu_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               last
);
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH:0]     sum;

  // Add into the upper half with carry, then shift the carry back into bit 2W-1.
  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_nxt = {sum, acc_q[WIDTH-1:1]};
    last    = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = mcand_in;
      mplier_d = mplier_in;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      mplier_d = mplier_q >> 1;
      acc_d    = acc_nxt;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: single-cycle logic/arith ops plus a multi-cycle MULTU producing Hi/Lo.
module alu_exec_unit
  import alu_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       Alu_Signal,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [WIDTH-1:0] Hi,
  output logic             bad_op
);
  state_e             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d, zero_q, zero_d, bad_q, bad_d;
  logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ok, mul_load, mul_step, mul_last;
  logic [2*WIDTH-1:0] mul_nxt;

  mul_shift_add #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .step      (mul_step),
    .mcand_in  (A),
    .mplier_in (B),
    .acc_nxt   (mul_nxt),
    .last      (mul_last)
  );

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (Alu_Signal)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_NOR:  alu_res = ~(A | B);
      default: alu_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    bad_d    = bad_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        if (Alu_Signal == OP_MULTU) begin
          mul_load = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_MUL;
        end else begin
          result_d = alu_ok ? alu_res : '0;
          zero_d   = alu_ok ? (alu_res == '0) : 1'b1;
          bad_d    = ~alu_ok;
          done_d   = 1'b1;
        end
      end
      // Product is captured on the final step's edge so done is visible
      // during FIN, giving start->done latency of WIDTH+1.
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          result_d = mul_nxt[WIDTH-1:0];
          hi_d     = mul_nxt[2*WIDTH-1:WIDTH];
          zero_d   = (mul_nxt[WIDTH-1:0] == '0);
          bad_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      bad_q    <= bad_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;
  assign Zero   = zero_q;
  assign Hi     = hi_q;
  assign bad_op = bad_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed vector bench for alu_exec_unit: single-cycle table plus multiply/reset sequences.
module tb_alu_exec_unit;
  import alu_defs::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  Alu_Signal;
  logic [31:0] A, B;
  logic        busy, done, Zero, bad_op;
  logic [31:0] Result, Hi;

  int total = 0;
  int passed = 0;

  alu_exec_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .Alu_Signal(Alu_Signal),
    .A(A), .B(B), .busy(busy), .done(done), .Result(Result),
    .Zero(Zero), .Hi(Hi), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        bad;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a MULTU from IDLE; a stray start with an ADD code is injected at ign_cyc
  // and operands are scrambled mid-run to show they are ignored.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int ign_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_z);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    logic [31:0] lo_s = '0, hi_s = '0;
    logic z_s = 1'b0;
    @(negedge clk);
    start = 1'b1; Alu_Signal = OP_MULTU; A = a; B = b;
    tick();
    for (int cyc = 1; cyc <= 36; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc; lo_s = Result; hi_s = Hi; z_s = Zero;
        end
      end
      @(negedge clk);
      start = (cyc == ign_cyc);
      Alu_Signal = OP_ADD; A = 32'h1234_5678; B = 32'h0F0F_0F0F;
      tick();
    end
    start = 1'b0;
    chk("mul_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("mul_done_cycle",  32'(done_cyc), 32'd33);
    chk("mul_done_count",  32'(done_cnt), 32'd1);
    chk("mul_hi",          hi_s, exp_hi);
    chk("mul_lo",          lo_s, exp_lo);
    chk("mul_zero",        32'(z_s), 32'(exp_z));
  endtask

  initial begin
    int dcnt;
    vecs[0]  = '{OP_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    vecs[1]  = '{OP_SUB, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
    vecs[2]  = '{OP_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
    vecs[3]  = '{OP_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};
    vecs[4]  = '{OP_NOR, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[5]  = '{4'b1111, 32'd3,         32'd4,          32'd0,          1'b1, 1'b1};
    vecs[6]  = '{OP_NOR, 32'hFFFF_0000,  32'h0000_FFFF,  32'd0,          1'b1, 1'b0};
    vecs[7]  = '{OP_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0};
    vecs[8]  = '{OP_OR,  32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[9]  = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
    vecs[10] = '{OP_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[11] = '{OP_SLT, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0};
    vecs[12] = '{4'b0011, 32'd1,         32'd1,          32'd0,          1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; Alu_Signal = OP_AND; A = '0; B = '0;
    tick(); tick();
    @(negedge clk); rst = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_zero", 32'(Zero), 32'd1);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_bad", 32'(bad_op), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (done) dcnt++; end
    chk("idle_no_done", 32'(dcnt), 32'd0);

    // Vectors issued back-to-back: start stays high across consecutive cycles.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      start = 1'b1; Alu_Signal = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
      tick();
      chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("v%0d_result", i), Result, vecs[i].res);
      chk($sformatf("v%0d_zero", i), 32'(Zero), 32'(vecs[i].zero));
      chk($sformatf("v%0d_bad", i), 32'(bad_op), 32'(vecs[i].bad));
      chk($sformatf("v%0d_hi", i), Hi, 32'd0);
    end
    @(negedge clk); start = 1'b0;
    tick();
    chk("after_vec_done_low", 32'(done), 32'd0);
    chk("hold_result", Result, 32'd0);
    chk("hold_bad", 32'(bad_op), 32'd1);

    run_mul(32'hFFFF_FFFF, 32'd2, 5, 32'd1, 32'hFFFF_FFFE, 1'b0);
    chk("post_mul_busy", 32'(busy), 32'd0);
    run_mul(32'h0001_0000, 32'h0001_0000, 0, 32'd1, 32'd0, 1'b1);

    // Unsupported op must leave Hi untouched.
    @(negedge clk); start = 1'b1; Alu_Signal = 4'b1010; A = 32'd1; B = 32'd1;
    tick();
    chk("badop_after_mul", 32'(bad_op), 32'd1);
    chk("badop_hi_held", Hi, 32'd1);

    // Reset together with start at cycle 10 of a multiply.
    @(negedge clk); start = 1'b1; Alu_Signal = OP_MULTU; A = 32'd7; B = 32'd9;
    tick();
    for (int c = 1; c < 10; c++) begin
      @(negedge clk); start = 1'b0;
      tick();
    end
    @(negedge clk); rst = 1'b1; start = 1'b1; Alu_Signal = OP_ADD; A = 32'd1; B = 32'd1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", Result, 32'd0);
    chk("abort_zero", 32'(Zero), 32'd1);
    chk("abort_hi", Hi, 32'd0);
    chk("abort_bad", 32'(bad_op), 32'd0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (done || busy) dcnt++; end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    @(negedge clk); start = 1'b1; Alu_Signal = OP_ADD; A = 32'd3; B = 32'd4;
    tick();
    chk("post_abort_done", 32'(done), 32'd1);
    chk("post_abort_result", Result, 32'd7);
    chk("post_abort_zero", 32'(Zero), 32'd0);
    @(negedge clk); start = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
